// File: rtl/clk_rst_pkg.sv
// Shared types and defaults for the clock/reset sequencer.
package clk_rst_pkg;

   // Sequencer states; the encoding is visible on the debug port.
   typedef enum logic [2:0] {
      ST_SYNC  = 3'd0,
      ST_HOLD  = 3'd1,
      ST_PREL  = 3'd2,
      ST_RUN   = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   localparam int DEF_SYNC_STAGES       = 2;
   localparam int DEF_HOLD_CYCLES       = 16;
   localparam int DEF_CORE_DELAY_CYCLES = 4;

   // Width of a counter that must reach (max(a, b) - 1).
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: assertion passes straight through, release is
// delayed by STAGES rising edges of clk.
module reset_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic sync_rst_n
);

   logic [STAGES-1:0] chain;

   // Shift a constant 1 in once the pad reset has been released.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: flops are written with <= so every stage samples its neighbour's
      // old value; a blocking = here would collapse the chain into one flop.
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], 1'b1};
      end
   end

   assign sync_rst_n = chain[STAGES-1];

endmodule

// File: rtl/clk_rst_ctrl.sv
// Clock/reset sequencer: orders peripheral and core reset release after the
// pad reset, handles warm reset via a drain state, and produces a
// programmable core clock enable with a glitch-free ratio change handshake.
module clk_rst_ctrl
   import clk_rst_pkg::*;
#(
   parameter int RST_SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int RST_HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int CORE_DELAY_CYCLES = DEF_CORE_DELAY_CYCLES,
   parameter int DIV_WIDTH         = 8,
   parameter int DIV_RESET         = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_sw_rst_req,
   input  logic                 i_div_wr,
   input  logic [DIV_WIDTH-1:0] i_div_val,
   output logic                 o_div_busy,
   output logic                 o_div_ack,
   output logic                 o_clk_en,
   output logic                 o_periph_reset_n,
   output logic                 o_core_reset_n,
   output logic [2:0]           o_state
);

   localparam int CNT_W = cnt_width(RST_HOLD_CYCLES, CORE_DELAY_CYCLES);
   localparam logic [CNT_W-1:0]     HOLD_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]     DELAY_LAST = CNT_W'(CORE_DELAY_CYCLES - 1);
   localparam logic [DIV_WIDTH-1:0] RATIO_RST  = DIV_WIDTH'(DIV_RESET);

   state_e               state;
   logic [CNT_W-1:0]     seq_cnt;
   logic                 sync_rst_n;

   logic [DIV_WIDTH-1:0] div_cnt;
   logic [DIV_WIDTH-1:0] div_cnt_nxt;
   logic [DIV_WIDTH-1:0] ratio;
   logic [DIV_WIDTH-1:0] pending;
   logic                 running;
   logic                 div_wrap;
   logic                 div_load;

   reset_sync #(
      .STAGES (RST_SYNC_STAGES)
   ) u_reset_sync (
      .clk        (clk),
      .rst_n      (reset_n),
      .sync_rst_n (sync_rst_n)
   );

   assign running = (state != ST_SYNC);
   assign o_state = state;

   // Reset sequencer: SYNC -> HOLD -> PREL -> RUN, warm reset via DRAIN.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= ST_SYNC;
         seq_cnt          <= '0;
         o_periph_reset_n <= 1'b0;
         o_core_reset_n   <= 1'b0;
      end else begin
         case (state)
            ST_SYNC: begin
               if (sync_rst_n) begin
                  state   <= ST_HOLD;
                  seq_cnt <= '0;
               end
            end
            ST_HOLD: begin
               if (seq_cnt == HOLD_LAST) begin
                  state            <= ST_PREL;
                  seq_cnt          <= '0;
                  o_periph_reset_n <= 1'b1;
               end else begin
                  seq_cnt <= seq_cnt + 1'b1;
               end
            end
            ST_PREL: begin
               if (seq_cnt == DELAY_LAST) begin
                  state          <= ST_RUN;
                  seq_cnt        <= '0;
                  o_core_reset_n <= 1'b1;
               end else begin
                  seq_cnt <= seq_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (i_sw_rst_req) begin
                  state          <= ST_DRAIN;
                  o_core_reset_n <= 1'b0;
               end
            end
            ST_DRAIN: begin
               // Leave only on an enable boundary so the core domain never
               // sees a truncated clock-enable period around the reset.
               if (div_cnt == '0) begin
                  state            <= ST_HOLD;
                  seq_cnt          <= '0;
                  o_periph_reset_n <= 1'b0;
               end
            end
            default: begin
               state            <= ST_SYNC;
               seq_cnt          <= '0;
               o_periph_reset_n <= 1'b0;
               o_core_reset_n   <= 1'b0;
            end
         endcase
      end
   end

   // Divider next-count: wrap at the current ratio, frozen at 0 in SYNC.
   always_comb begin
      // NOTE: every output of this block gets a value before any branch,
      // otherwise an unassigned path would infer a latch.
      div_wrap    = (div_cnt == ratio);
      div_load    = running && o_div_busy && div_wrap;
      div_cnt_nxt = div_wrap ? '0 : div_cnt + 1'b1;
      if (!running) begin
         div_cnt_nxt = '0;
      end
   end

   // Divider counter, registered enable and ratio-change handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt    <= '0;
         ratio      <= RATIO_RST;
         // NOTE: the pending ratio is reset as well even though busy guards
         // it, so the register never carries X into a ratio load.
         pending    <= RATIO_RST;
         o_div_busy <= 1'b0;
         o_div_ack  <= 1'b0;
         o_clk_en   <= 1'b0;
      end else begin
         div_cnt   <= div_cnt_nxt;
         o_clk_en  <= running && (div_cnt_nxt == '0);
         o_div_ack <= div_load;
         if (div_load) begin
            ratio      <= pending;
            o_div_busy <= 1'b0;
         end else if (i_div_wr && !o_div_busy) begin
            pending    <= i_div_val;
            o_div_busy <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Self-checking bench for clk_rst_ctrl: directed sequences plus random
// divider writes and warm resets, compared against an event-time model.
module tb_clk_rst_ctrl;

   localparam int SYNC_STAGES = 2;
   localparam int HOLD        = 16;
   localparam int DELAY       = 4;
   localparam int DW          = 8;
   localparam int DIV_RST     = 0;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          sw_req = 1'b0;
   logic          div_wr = 1'b0;
   logic [DW-1:0] div_val = '0;
   logic          div_busy, div_ack, clk_en, periph_rst_n, core_rst_n;
   logic [2:0]    state;

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;

   // Model: times are counted in rising edges since pad reset release.
   bit m_up;
   int m_n;
   int m_ratio, m_pend, m_next_en;
   bit m_busy, m_drain;
   bit e_en, e_ack, e_periph, e_core;
   int t_periph, t_core;

   clk_rst_ctrl #(
      .RST_SYNC_STAGES   (SYNC_STAGES),
      .RST_HOLD_CYCLES   (HOLD),
      .CORE_DELAY_CYCLES (DELAY),
      .DIV_WIDTH         (DW),
      .DIV_RESET         (DIV_RST)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .i_sw_rst_req     (sw_req),
      .i_div_wr         (div_wr),
      .i_div_val        (div_val),
      .o_div_busy       (div_busy),
      .o_div_ack        (div_ack),
      .o_clk_en         (clk_en),
      .o_periph_reset_n (periph_rst_n),
      .o_core_reset_n   (core_rst_n),
      .o_state          (state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [2:0] exp_state();
      if (!m_up || m_n < SYNC_STAGES + 1) return 3'd0;
      if (m_drain)  return 3'd4;
      if (e_core)   return 3'd3;
      if (e_periph) return 3'd2;
      return 3'd1;
   endfunction

   function automatic logic [7:0] exp_vec();
      return {m_busy, e_ack, e_en, e_periph, e_core, exp_state()};
   endfunction

   function automatic logic [7:0] dut_vec();
      return {div_busy, div_ack, clk_en, periph_rst_n, core_rst_n, state};
   endfunction

   task automatic model_clear();
      m_up = 0; m_n = 0;
      m_ratio = DIV_RST; m_pend = 0; m_next_en = 0;
      m_busy = 0; m_drain = 0;
      e_en = 0; e_ack = 0; e_periph = 0; e_core = 0;
      t_periph = -1; t_core = -1;
   endtask

   // Advance the model by one rising edge using the inputs seen at that edge.
   task automatic model_edge();
      bit busy_b, en_b, core_b, drain_b, en_edge;
      if (!m_up) return;
      m_n++;
      busy_b = m_busy; en_b = e_en; core_b = e_core; drain_b = m_drain;
      e_ack = 0;
      // The enable period runs once out of SYNC; first running edge is an enable.
      if (m_n >= SYNC_STAGES + 2) begin
         en_edge = (m_n == SYNC_STAGES + 2) || (m_n == m_next_en);
         if (en_edge) begin
            if (busy_b) begin
               m_ratio = m_pend; m_busy = 0; e_ack = 1;
            end
            m_next_en = m_n + m_ratio + 1;
         end
         e_en = en_edge;
      end else begin
         e_en = 0;
      end
      if (div_wr && !busy_b) begin
         m_pend = int'(div_val); m_busy = 1;
      end
      if (m_n == SYNC_STAGES + HOLD + 1 || m_n == t_periph) begin
         e_periph = 1; t_periph = -1; t_core = m_n + DELAY;
      end
      if (m_n == t_core) begin
         e_core = 1; t_core = -1;
      end
      if (core_b && sw_req) begin
         e_core = 0; m_drain = 1;
      end
      if (drain_b && en_b) begin
         m_drain = 0; e_periph = 0; t_periph = m_n + HOLD;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      edge_cnt++;
      #1;
      check("cycle", dut_vec(), exp_vec());
   endtask

   task automatic pulse_wr(input int val);
      div_wr = 1'b1; div_val = DW'(val);
      tick();
      div_wr = 1'b0;
   endtask

   task automatic pulse_req();
      sw_req = 1'b1;
      tick();
      sw_req = 1'b0;
   endtask

   task automatic count_en(input int n, output int en, output int ack);
      en = 0; ack = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         en  += int'(clk_en);
         ack += int'(div_ack);
      end
   endtask

   task automatic wait_ack(input string tag);
      int k = 0;
      while (!div_ack && k < 40) begin tick(); k++; end
      check({tag, "_ack_seen"}, div_ack, 1'b1);
   endtask

   task automatic wait_run(input string tag);
      int k = 0;
      while (!core_rst_n && k < 60) begin tick(); k++; end
      check({tag, "_run"}, core_rst_n, 1'b1);
   endtask

   // Assert the pad reset mid-cycle, check the asynchronous clear, release.
   task automatic pad_reset(input string tag);
      @(negedge clk);
      reset_n = 1'b0;
      model_clear();
      #1;
      check({tag, "_async_clr"}, dut_vec(), 8'h00);
      repeat (2) tick();
      @(negedge clk);
      reset_n = 1'b1;
      m_up = 1; m_n = 0; edge_cnt = 0;
   endtask

   initial begin
      int k, en, ack;
      model_clear();
      #1 reset_n = 1'b0;
      #1 check("reset_state", dut_vec(), 8'h00);
      repeat (3) tick();

      // Release from pad reset: periph after sync+hold+1 edges, core 4 later.
      @(negedge clk);
      reset_n = 1'b1;
      m_up = 1; m_n = 0; edge_cnt = 0;
      k = 0;
      while (!periph_rst_n && k < 40) begin tick(); k++; end
      check("periph_latency", k, SYNC_STAGES + HOLD + 1);
      k = 0;
      while (!core_rst_n && k < 20) begin tick(); k++; end
      check("core_gap", k, DELAY);
      count_en(8, en, ack);
      check("en_constant", en, 8);

      // Ratio 3, then back to 0.
      pulse_wr(3);
      count_en(12, en, ack);
      check("div3_ack", ack, 1);
      check("div3_en", en, 3);
      pulse_wr(0);
      count_en(12, en, ack);
      check("div0_ack", ack, 1);
      count_en(6, en, ack);
      check("div0_en", en, 6);

      // Busy drop: second write lands while the first is pending.
      pulse_wr(7);
      wait_ack("div7");
      pulse_wr(2);
      tick(); tick();
      check("drop_busy", div_busy, 1'b1);
      pulse_wr(5);
      count_en(16, en, ack);
      check("drop_single_ack", ack, 1);
      count_en(9, en, ack);
      check("drop_period3", en, 3);

      // Warm reset with ratio 3: drain, re-release, ratio kept.
      pulse_wr(3);
      wait_ack("warm_div");
      pulse_req();
      check("warm_core_low", core_rst_n, 1'b0);
      check("warm_drain_state", state, 3'd4);
      k = 0;
      while (periph_rst_n && k < 10) begin tick(); k++; end
      check("warm_drain_len", (k <= 4), 1'b1);
      k = 0;
      while (!periph_rst_n && k < 40) begin tick(); k++; end
      check("warm_hold", k, HOLD);
      k = 0;
      while (!core_rst_n && k < 20) begin tick(); k++; end
      check("warm_core_gap", k, DELAY);
      count_en(8, en, ack);
      check("warm_ratio_kept", en, 2);

      // Warm-reset requests during HOLD and PREL are ignored.
      pad_reset("sync_ign");
      repeat (5) tick();
      pulse_req();
      while (!periph_rst_n && edge_cnt < 40) tick();
      pulse_req();
      while (!core_rst_n && edge_cnt < 60) tick();
      check("sync_ign_core_edge", edge_cnt, SYNC_STAGES + HOLD + 1 + DELAY);
      check("sync_ign_state", state, 3'd3);

      // Abort mid-DRAIN with a pending ratio accepted alongside the request.
      pulse_wr(5);
      wait_ack("abort_div");
      tick();
      sw_req = 1'b1; div_wr = 1'b1; div_val = 8'd2;
      tick();
      sw_req = 1'b0; div_wr = 1'b0;
      check("both_accepted_state", state, 3'd4);
      check("both_accepted_busy", div_busy, 1'b1);
      pad_reset("abort_drain");
      wait_run("abort_drain");
      check("abort_busy_clear", div_busy, 1'b0);
      count_en(6, en, ack);
      check("abort_ratio_reset", en, 6);

      // Abort mid-HOLD.
      pad_reset("abort_hold_pre");
      repeat (8) tick();
      check("abort_hold_state", state, 3'd1);
      pad_reset("abort_hold");
      wait_run("abort_hold");

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         if (c == 200) begin
            div_wr = 1'b0; sw_req = 1'b0;
            pad_reset("rand");
         end
         div_wr  = ($urandom_range(0, 5) == 0);
         div_val = DW'($urandom_range(0, 4));
         sw_req  = ($urandom_range(0, 39) == 0);
         tick();
      end
      div_wr = 1'b0; sw_req = 1'b0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_rst_ctrl.md
Name: clk_rst_ctrl

Overview:
Clock/reset sequencer downstream of the clock pad wrapper.
- Takes the pad clock and the pad reset, and generates ordered, synchronously-released resets for peripherals and then the core.
- Generates a programmable clock-enable divider for the core domain.
- Handles a software-requested warm reset.
- Sits in the SoC top between the pad ring and the core/peripheral subsystem.

Parameters:
RST_SYNC_STAGES, 2, flops in the reset-deassert synchronizer (min 2)
RST_HOLD_CYCLES, 16, cycles both resets stay asserted after sync release (min 1)
CORE_DELAY_CYCLES, 4, cycles between peripheral and core reset release (min 1)
DIV_WIDTH, 8, width of divider ratio field
DIV_RESET, 0, divider value after reset (0 = enable every cycle)

Ports:
clk  input  1  pad clock (from clock pad wrapper)
reset_n  input  1  asynchronous active-low reset from pad
i_sw_rst_req  input  1  one-cycle pulse: request warm reset (from core-domain register)
i_div_wr  input  1  write strobe for new divider ratio
i_div_val  input  DIV_WIDTH  new divider ratio (enable period = val+1 cycles)
o_div_busy  output  1  divider change pending
o_div_ack  output  1  one-cycle pulse when new ratio takes effect
o_clk_en  output  1  core-domain clock enable
o_periph_reset_n  output  1  peripheral reset, active low
o_core_reset_n  output  1  core reset, active low
o_state  output  3  current FSM state (debug)

Behaviour:
Reset and synchronizer:
- reset_n low asynchronously forces o_periph_reset_n=0, o_core_reset_n=0, o_clk_en=0, o_div_busy=0, o_div_ack=0, divider counter=0, ratio=DIV_RESET, state=SYNC.
- Deassertion passes through a RST_SYNC_STAGES-deep synchronizer. Assertion is never synchronized.

FSM states (o_state encoding):
- SYNC=0: wait for synchronizer output high, then go to HOLD with hold counter=0.
- HOLD=1: counter increments each cycle. At RST_HOLD_CYCLES-1 go to PREL.
- PREL=2: o_periph_reset_n=1 on entry. Counter counts CORE_DELAY_CYCLES, then go to RUN.
- RUN=3: o_core_reset_n=1.
- DRAIN=4: entered from RUN on i_sw_rst_req. o_core_reset_n=0 immediately (registered, next edge). Wait until divider counter==0, then go to HOLD with o_periph_reset_n=0.
- i_sw_rst_req outside RUN is ignored.
- Pad reset during any state, including DRAIN, returns to SYNC asynchronously.

Reset outputs and latency:
- Both reset outputs are registered and glitch-free.
- From reset_n rise to o_periph_reset_n=1: RST_SYNC_STAGES+RST_HOLD_CYCLES+1 edges (±1 for sync metastability).
- o_core_reset_n rises exactly CORE_DELAY_CYCLES edges after o_periph_reset_n.

Divider:
- Counter runs in HOLD, PREL, RUN and DRAIN; held at 0 in SYNC.
- o_clk_en = (counter==0), registered.
- Counter wraps at the current ratio. Ratio 0 gives o_clk_en constantly 1 outside SYNC.

Divider change handshake:
- i_div_wr with o_div_busy=0 latches i_div_val into a pending register and sets o_div_busy.
- At the next wrap (counter==ratio, or immediately if ratio==0) the ratio loads, the counter restarts at 0, o_div_busy clears, and o_div_ack pulses for 1 cycle.
- i_div_wr while busy is dropped, with no ack.
- Writing the same value still produces an ack.
- A warm reset does not alter the ratio. A pending change survives DRAIN/HOLD.
- Pad reset clears the pending change and restores DIV_RESET.

Simultaneous events:
- i_sw_rst_req and i_div_wr in the same cycle: both are accepted.

Decomposition:
- Package clk_rst_pkg: state enum typedef (3-bit), default constants for hold/delay cycles.
- Sub-module reset_sync: async-assert/sync-deassert flop chain, parameter STAGES.
- FSM and divider stay in clk_rst_ctrl.

Test Plan:
- Reset release: defaults, reset_n rises at t0 -> o_periph_reset_n=1 after 19 edges (±1), o_core_reset_n=1 exactly 4 edges later, o_clk_en constantly 1 after SYNC.
- Divider set: in RUN, write div_val=3 -> o_div_ack once, then o_clk_en high 1 cycle in 4. Write 0 -> ack at next wrap, enable constant.
- Busy drop: div=7, write 2 then write 5 two cycles later -> single ack, resulting period 3, second write ignored.
- Warm reset: div=3, pulse i_sw_rst_req -> core reset low next edge, periph reset low at next counter==0, then re-release after 16+4 cycles, ratio still 3.
- Async abort: drop reset_n mid-DRAIN and mid-HOLD -> all outputs 0 within the same cycle with no clock edge, ratio back to 0, o_div_busy=0.
- Sync-window ignore: i_sw_rst_req pulse during HOLD/PREL -> no effect, core release timing unchanged.
